// File: rtl/attn_result_reader.sv
// attn_result_reader
//   Walks every (line, col) block of the attention result BRAM in order,
//   reading one 4096-bit block at a time and streaming it out LSB-first as
//   DATA_W-bit words over a valid/ready handshake.
//
//   Ports
//     I_CLK, I_RST          clock, async active-high reset
//     I_ATTN_END            result available (level); dropping it aborts
//     O_RD_BRAM_EN          one-cycle read request strobe
//     O_RD_BRAM_LINE/COL    registered block address, stable per block
//     I_BRAM_RD_VLD/MAT     read response, accepted only while waiting
//     O_DATA/O_VALID        serialized word stream
//     I_READY               sink back-pressure
//     O_LAST                final word of the final block
//     O_DONE                whole result drained, held until I_ATTN_END drops
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for I_ATTN_END
//   REQ   | read strobe for current (line, col) is on the bus
//   WAIT  | waiting for BRAM read data (no timeout)
//   SHIFT | presenting buffered words, one per accepted handshake
//   NEXT  | advance (line, col), decide REQ or DONE
//   DONE  | O_DONE held high until I_ATTN_END drops
module attn_result_reader #(
  parameter int DATA_W = 16,
  parameter int N_LINE = 64,
  parameter int N_COL  = 8
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_ATTN_END,
  output logic              O_RD_BRAM_EN,
  output logic [5:0]        O_RD_BRAM_LINE,
  output logic [2:0]        O_RD_BRAM_COL,
  input  logic              I_BRAM_RD_VLD,
  input  logic [4095:0]     I_BRAM_RD_MAT,
  output logic [DATA_W-1:0] O_DATA,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic              O_LAST,
  output logic              O_DONE
);

  localparam int BLK_W   = 4096;
  localparam int N_CHUNK = BLK_W / DATA_W;
  localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  localparam logic [CHUNK_W-1:0] CHUNK_MAX = CHUNK_W'(N_CHUNK - 1);
  // Second-to-last chunk; only reachable when a block holds 2+ words.
  localparam logic [CHUNK_W-1:0] CHUNK_PEN = CHUNK_W'(N_CHUNK - 2);
  localparam logic [5:0]         LINE_MAX  = 6'(N_LINE - 1);
  localparam logic [2:0]         COL_MAX   = 3'(N_COL - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, NEXT, DONE} state_t;

  state_t             state;
  logic [BLK_W-1:0]   data_buf;
  logic [CHUNK_W-1:0] chunk;
  logic [5:0]         line;
  logic [2:0]         col;
  logic               final_blk;
  logic               abort;

  assign final_blk      = (line == LINE_MAX) && (col == COL_MAX);
  assign abort          = !I_ATTN_END &&
                          (state == REQ || state == WAIT ||
                           state == SHIFT || state == NEXT);
  assign O_RD_BRAM_LINE = line;
  assign O_RD_BRAM_COL  = col;
  assign O_DATA         = data_buf[DATA_W-1:0];

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state        <= IDLE;
      data_buf     <= '0;
      chunk        <= '0;
      line         <= '0;
      col          <= '0;
      O_RD_BRAM_EN <= 1'b0;
      O_VALID      <= 1'b0;
      O_LAST       <= 1'b0;
      O_DONE       <= 1'b0;
    end else if (abort) begin
      // Abort wins over any handshake in flight this cycle.
      state        <= IDLE;
      chunk        <= '0;
      line         <= '0;
      col          <= '0;
      O_RD_BRAM_EN <= 1'b0;
      O_VALID      <= 1'b0;
      O_LAST       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_ATTN_END) begin
            state        <= REQ;
            line         <= '0;
            col          <= '0;
            O_RD_BRAM_EN <= 1'b1;
          end
        end
        REQ: begin
          state        <= WAIT;
          O_RD_BRAM_EN <= 1'b0;
        end
        WAIT: begin
          if (I_BRAM_RD_VLD) begin
            state    <= SHIFT;
            data_buf <= I_BRAM_RD_MAT;
            chunk    <= '0;
            O_VALID  <= 1'b1;
            O_LAST   <= final_blk && (N_CHUNK == 1);
          end
        end
        SHIFT: begin
          if (I_READY) begin
            data_buf <= data_buf >> DATA_W;
            chunk    <= chunk + 1'b1;
            if (chunk == CHUNK_MAX) begin
              state   <= NEXT;
              O_VALID <= 1'b0;
              O_LAST  <= 1'b0;
            end else begin
              // Raise LAST together with the word it marks.
              O_LAST <= final_blk && (chunk == CHUNK_PEN);
            end
          end
        end
        NEXT: begin
          if (final_blk) begin
            state  <= DONE;
            line   <= '0;
            col    <= '0;
            O_DONE <= 1'b1;
          end else begin
            state        <= REQ;
            O_RD_BRAM_EN <= 1'b1;
            if (col == COL_MAX) begin
              col  <= '0;
              line <= line + 6'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        DONE: begin
          if (!I_ATTN_END) begin
            state  <= IDLE;
            O_DONE <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_result_reader.sv
// Bench for attn_result_reader. Two instances share the clock and reset:
// dut_a uses 16-bit words (256 words per block) for the directed block,
// back-pressure, spurious-valid, abort and reset scenarios; dut_b uses
// 512-bit words (8 words per block) so the full 64x8 sweep stays short.
// The reference is a word queue filled from each block the bench returns,
// plus a request index that names the expected (line, col) order.
module tb_attn_result_reader;

  logic clk = 1'b0;
  logic rst;

  logic           a_attn, a_en, a_vld, a_valid, a_ready, a_last, a_done;
  logic [5:0]     a_line;
  logic [2:0]     a_col;
  logic [4095:0]  a_mat;
  logic [15:0]    a_data;

  logic           b_attn, b_en, b_vld, b_valid, b_ready, b_last, b_done;
  logic [5:0]     b_line;
  logic [2:0]     b_col;
  logic [4095:0]  b_mat;
  logic [511:0]   b_data;

  attn_result_reader #(.DATA_W(16)) dut_a (
    .I_CLK(clk), .I_RST(rst), .I_ATTN_END(a_attn),
    .O_RD_BRAM_EN(a_en), .O_RD_BRAM_LINE(a_line), .O_RD_BRAM_COL(a_col),
    .I_BRAM_RD_VLD(a_vld), .I_BRAM_RD_MAT(a_mat),
    .O_DATA(a_data), .O_VALID(a_valid), .I_READY(a_ready),
    .O_LAST(a_last), .O_DONE(a_done)
  );

  attn_result_reader #(.DATA_W(512)) dut_b (
    .I_CLK(clk), .I_RST(rst), .I_ATTN_END(b_attn),
    .O_RD_BRAM_EN(b_en), .O_RD_BRAM_LINE(b_line), .O_RD_BRAM_COL(b_col),
    .I_BRAM_RD_VLD(b_vld), .I_BRAM_RD_MAT(b_mat),
    .O_DATA(b_data), .O_VALID(b_valid), .I_READY(b_ready),
    .O_LAST(b_last), .O_DONE(b_done)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [15:0]   a_q[$];
  logic [511:0]  b_q[$];
  int            a_req_idx = 0, b_req_idx = 0;
  int            a_cnt = 0, b_cnt = 0, a_lat_min = 1;
  int            b_pop = 0, b_last_cnt = 0;
  bit            a_bp = 0, a_spur = 0, a_fixed = 0;
  logic [4095:0] fixed_blk;

  logic          a_stall_q = 0, a_en_q = 0, b_stall_q = 0, b_en_q = 0, b_last_q = 0;
  logic [15:0]   a_data_q = '0;
  logic [511:0]  b_data_q = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  function automatic logic [4095:0] rand_blk();
    logic [4095:0] r;
    for (int i = 0; i < 128; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk); #1;
    a_vld = 1'b0;
    if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        a_vld = 1'b1;
        a_mat = a_fixed ? fixed_blk : rand_blk();
        for (int i = 0; i < 256; i++) a_q.push_back(a_mat[i*16 +: 16]);
      end
    end else if (a_spur && a_valid && $urandom_range(0, 3) == 0) begin
      a_vld = 1'b1;
      a_mat = rand_blk();
    end
    if (a_en) a_cnt = int'($urandom_range(3, a_lat_min));
    a_ready = a_bp ? ($urandom_range(0, 1) == 1) : 1'b1;

    b_vld = 1'b0;
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        b_vld = 1'b1;
        b_mat = rand_blk();
        for (int i = 0; i < 8; i++) b_q.push_back(b_mat[i*512 +: 512]);
      end
    end
    if (b_en) b_cnt = int'($urandom_range(3, 1));
    b_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_a_valid(input int budget);
    int c;
    c = 0;
    while (!a_valid && c < budget) begin tick(); c++; end
    chk("a_valid_wait", a_valid, 1);
  endtask

  task automatic run_until_a_req(input int n, input int budget);
    int c;
    c = 0;
    while (a_req_idx < n && c < budget) begin tick(); c++; end
    chk("a_req_wait", a_req_idx >= n, 1);
  endtask

  task automatic abort_a();
    a_attn  = 1'b0;
    a_ready = 1'b1;
    tick();
    chk("abort_valid", a_valid, 0);
    chk("abort_en", a_en, 0);
    chk("abort_last", a_last, 0);
    chk("abort_line", a_line, 0);
    chk("abort_col", a_col, 0);
    a_q.delete();
    a_cnt     = 0;
    a_req_idx = 0;
    tick();
  endtask

  // compare process, both instances, every falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      a_stall_q = 0; a_en_q = 0; b_stall_q = 0; b_en_q = 0;
    end else begin
      if (a_en) begin
        chk("a_req_line", a_line, a_req_idx / 8);
        chk("a_req_col", a_col, a_req_idx % 8);
        chk("a_en_single", a_en_q, 0);
        chk("a_prev_drained", a_q.size(), 0);
        a_req_idx++;
      end
      if (a_valid) begin
        chk("a_word_expected", a_q.size() != 0, 1);
        if (a_q.size() != 0) chk("a_data", a_data, a_q[0]);
        chk("a_last", a_last, 0);
        if (a_stall_q) chk("a_hold", a_data, a_data_q);
        if (a_ready && a_attn && a_q.size() != 0) void'(a_q.pop_front());
      end
      a_stall_q = a_valid && !a_ready && a_attn;
      a_data_q  = a_data;
      a_en_q    = a_en;

      if (b_en) begin
        chk("b_req_line", b_line, b_req_idx / 8);
        chk("b_req_col", b_col, b_req_idx % 8);
        chk("b_en_single", b_en_q, 0);
        chk("b_prev_drained", b_q.size(), 0);
        b_req_idx++;
      end
      if (b_valid) begin
        chk("b_word_expected", b_q.size() != 0, 1);
        if (b_q.size() != 0) chk("b_data", b_data, b_q[0]);
        chk("b_last", b_last, b_pop == 4095);
        if (b_stall_q) begin
          chk("b_hold_data", b_data, b_data_q);
          chk("b_hold_last", b_last, b_last_q);
        end
        if (b_ready && b_attn && b_q.size() != 0) begin
          void'(b_q.pop_front());
          b_pop++;
          if (b_last) b_last_cnt++;
        end
      end else begin
        chk("b_last_novalid", b_last, 0);
      end
      if (b_pop < 4096) chk("b_done_early", b_done, 0);
      b_stall_q = b_valid && !b_ready && b_attn;
      b_data_q  = b_data;
      b_last_q  = b_last;
      b_en_q    = b_en;
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    a_attn = 0; a_vld = 0; a_ready = 0; a_mat = '0;
    b_attn = 0; b_vld = 0; b_ready = 0; b_mat = '0;
    for (int i = 0; i < 256; i++) fixed_blk[i*16 +: 16] = 16'(i + 1);

    // reset state
    repeat (3) tick();
    chk("rst_a_en", a_en, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_last", a_last, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_line", a_line, 0);
    chk("rst_a_col", a_col, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_done", b_done, 0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", a_en, 0);

    // fixed block 1,2,3,... with ready held high
    a_fixed = 1; a_attn = 1;
    tick();
    chk("start_en", a_en, 1);
    chk("start_line", a_line, 0);
    chk("start_col", a_col, 0);
    wait_a_valid(20);
    for (int i = 0; i < 256; i++) begin
      chk("blk_valid", a_valid, 1);
      chk("blk_word", a_data, 16'(i + 1));
      tick();
    end
    chk("blk_next_gap", a_valid, 0);
    a_fixed = 0;
    tick();
    chk("blk_req2_en", a_en, 1);
    chk("blk_req2_col", a_col, 1);
    abort_a();

    // random back-pressure with spurious read-valid pulses during SHIFT
    a_bp = 1; a_spur = 1; a_attn = 1;
    run_until_a_req(4, 4000);
    wait_a_valid(20);
    repeat (7) tick();
    abort_a();
    a_bp = 0; a_spur = 0;

    // abort while waiting on block (5,3), then restart from (0,0)
    a_lat_min = 2; a_attn = 1;
    run_until_a_req(44, 16000);
    chk("abort_pt_line", a_line, 5);
    chk("abort_pt_col", a_col, 3);
    chk("abort_pt_wait", a_valid | a_en, 0);
    abort_a();
    repeat (3) begin
      tick();
      chk("idle_no_req", a_en, 0);
      chk("idle_no_valid", a_valid, 0);
    end
    a_lat_min = 1; a_attn = 1;
    tick();
    chk("restart_en", a_en, 1);
    chk("restart_line", a_line, 0);
    chk("restart_col", a_col, 0);

    // asynchronous reset in the middle of block (0,2)
    run_until_a_req(3, 2000);
    wait_a_valid(20);
    repeat (10) tick();
    chk("pre_rst_valid", a_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_en", a_en, 0);
    chk("arst_done", a_done, 0);
    chk("arst_col", a_col, 0);
    chk("arst_data", a_data, 0);
    a_attn = 0;
    a_q.delete(); a_cnt = 0; a_req_idx = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_line", a_line, 0);
    chk("post_rst_col", a_col, 0);
    tick();
    chk("post_rst_idle", a_en, 0);
    a_attn = 1;
    tick();
    chk("post_rst_en", a_en, 1);
    chk("post_rst_req_line", a_line, 0);
    chk("post_rst_req_col", a_col, 0);
    abort_a();

    // full 64x8 sweep on the wide-word instance
    b_attn = 1;
    c = 0;
    while (!b_done && c < 20000) begin tick(); c++; end
    chk("sweep_done", b_done, 1);
    chk("sweep_words", b_pop, 4096);
    chk("sweep_last_once", b_last_cnt, 1);
    chk("sweep_reqs", b_req_idx, 512);
    chk("sweep_valid_off", b_valid, 0);
    chk("sweep_queue_empty", b_q.size(), 0);
    tick();
    chk("done_holds", b_done, 1);
    chk("done_no_req", b_en, 0);
    b_attn = 0;
    tick();
    chk("done_clears", b_done, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/attn_result_reader.md
ATTN_RESULT_READER -- requirements
Module: attn_result_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, output word width; 4096 SHALL be an integer multiple of DATA_W.
REQ-002 SHALL have parameter N_LINE, default 64, number of BRAM lines.
REQ-003 SHALL have parameter N_COL, default 8, columns per line.
REQ-004 Port I_CLK, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port I_RST, input, 1: reset, asynchronous and active-high.
REQ-006 Port I_ATTN_END, input, 1: attention result available; level signal.
REQ-007 Port O_RD_BRAM_EN, output, 1: BRAM read request strobe.
REQ-008 Port O_RD_BRAM_LINE, output, 6: requested line index.
REQ-009 Port O_RD_BRAM_COL, output, 3: requested column index.
REQ-010 Port I_BRAM_RD_VLD, input, 1: read data valid.
REQ-011 Port I_BRAM_RD_MAT, input, 4096: read data block.
REQ-012 Port O_DATA, output, DATA_W: serialized output word.
REQ-013 Port O_VALID, output, 1: O_DATA valid.
REQ-014 Port I_READY, input, 1: sink accepts O_DATA.
REQ-015 Port O_LAST, output, 1: marks the final word of the full result.
REQ-016 Port O_DONE, output, 1: full result drained.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, SHIFT, NEXT and DONE.
REQ-018 In IDLE, I_ATTN_END=1 sampled at edge N SHALL move to REQ with line=0 and col=0, so O_RD_BRAM_EN=1 during cycle N+1.
REQ-019 O_RD_BRAM_EN SHALL be high for exactly one cycle per REQ visit; the FSM SHALL then move to WAIT.
REQ-020 O_RD_BRAM_LINE and O_RD_BRAM_COL SHALL be registered and SHALL hold stable from REQ until NEXT.
REQ-021 In WAIT, I_BRAM_RD_VLD=1 SHALL capture I_BRAM_RD_MAT into a 4096-bit buffer, clear the chunk counter and move to SHIFT.
REQ-022 WAIT SHALL have no timeout.
REQ-023 I_BRAM_RD_VLD SHALL be ignored in every state other than WAIT.
REQ-024 In SHIFT, O_VALID SHALL be 1 and O_DATA SHALL be buf[DATA_W-1:0], so words leave LSB first.
REQ-025 On O_VALID & I_READY in SHIFT, the buffer SHALL shift right by DATA_W and the chunk counter SHALL increment.
REQ-026 While O_VALID=1 and I_READY=0, O_DATA and O_LAST SHALL hold stable.
REQ-027 A handshake with chunk counter = 4096/DATA_W-1 SHALL move the FSM to NEXT.
REQ-028 NEXT SHALL last one cycle, during which O_VALID=0.
REQ-029 In NEXT, col SHALL increment; col N_COL-1 SHALL wrap to 0 and increment line.
REQ-030 If NEXT is entered with line=N_LINE-1 and col=N_COL-1, the FSM SHALL go to DONE; otherwise it SHALL go to REQ.
REQ-031 O_LAST SHALL be 1 only while SHIFT presents the final chunk of line N_LINE-1, col N_COL-1.
REQ-032 In DONE, O_DONE SHALL be 1; the FSM SHALL return to IDLE when I_ATTN_END=0, and O_DONE SHALL then clear.
REQ-033 I_ATTN_END=0 sampled in REQ, WAIT, SHIFT or NEXT SHALL abort the transfer to IDLE on the next edge.
REQ-034 An abort SHALL drop O_VALID with no O_LAST, and line, col and chunk counter SHALL clear.
REQ-035 An abort SHALL override I_READY in the same cycle.
REQ-036 A full transfer SHALL produce exactly N_LINE*N_COL*4096/DATA_W accepted words, which is 131072 at the defaults.
REQ-037 The block SHALL sustain one word per cycle in SHIFT whenever I_READY=1.

Reset
REQ-038 While I_RST=1, the FSM SHALL be in IDLE and all outputs SHALL be 0.
REQ-039 While I_RST=1, line, col, chunk counter and buffer SHALL be 0.
REQ-040 I_RST asserted mid-transfer SHALL take effect immediately without waiting for a clock.
REQ-041 After I_RST is released, a new transfer SHALL need I_ATTN_END sampled high in IDLE.

Verification
REQ-042 Reset: assert I_RST mid-SHIFT -> O_VALID, O_RD_BRAM_EN and O_DONE are 0 asynchronously; after release, line=0 and col=0.
REQ-043 Single block with I_READY held 1 and block = 4096'h...0003_0002_0001 -> O_DATA sequence is 1, 2, 3, ... on consecutive cycles, with 256 words before NEXT.
REQ-044 Back-pressure: toggle I_READY randomly -> O_DATA stable while stalled, no word lost or duplicated, scoreboard matches the block.
REQ-045 Full sweep: the request sequence is (0,0), (0,1) ... (0,7), (1,0) ... (63,7); there are 131072 words in total; O_LAST occurs exactly once, on the final word; O_DONE is then 1.
REQ-046 Abort: drop I_ATTN_END during WAIT of (5,3) -> IDLE next cycle with no output; re-raising it restarts from (0,0).
REQ-047 Spurious valid: pulse I_BRAM_RD_VLD during SHIFT with different data -> buffer unchanged and output stream intact.
